// File: rtl/ripple_pkg.sv
// Shared types, constants and pattern helpers for the ripple monitor.
package ripple_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    LOCK   = 2'd3
  } state_t;

  localparam int   GOOD_TO_LOCK = 3;
  localparam logic DIR_UP       = 1'b1;

  function automatic logic [2:0] onehot_idx(input logic [7:0] pat);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [7:0] pat);
    return (pat != 8'd0) && ((pat & (pat - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/ripple_dwell_cnt.sv
// Saturating dwell counter; value is cycles since the last clear, minus one.
module ripple_dwell_cnt #(
  parameter int SHIFT_TIME = 50000000,
  parameter int TOL        = 16,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic in_window,
  output logic timeout
);

  // Counter holds (dwell - 1), so the window bounds are shifted down by one.
  localparam logic [CNT_W-1:0] LO      = CNT_W'(SHIFT_TIME - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(SHIFT_TIME + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Clear on request, otherwise count up and stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + ONE;
    end else begin
      cnt <= cnt;
    end
  end

  assign in_window = (cnt >= LO) && (cnt <= HI);
  assign timeout   = (cnt > HI);

endmodule

// File: rtl/ripple_monitor.sv
// Receive-side checker for the one-hot LED ripple: decodes the lit position,
// learns the direction, checks step dwell and reports lock status and errors.
module ripple_monitor
  import ripple_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SHIFT_TIME = 50000000,
  parameter int TOL        = 16,
  parameter int CNT_W      = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pat_in,
  output logic [2:0]       pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             locked,
  output logic             err_onehot,
  output logic             err_step,
  output logic             err_timing
);

  localparam logic [1:0] LAST_GOOD = 2'(GOOD_TO_LOCK - 1);

  logic [WIDTH-1:0] pat_q, pat_prev;
  state_t           state, state_nxt;
  logic [2:0]       pos_nxt, idx;
  logic [1:0]       good, good_nxt;
  logic             dir_nxt, step, oh, up, dn, dwell_clr, in_window, timeout;
  logic             eo_nxt, es_nxt, et_nxt;

  // Input sample and one-cycle history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= {WIDTH{1'b0}};
      pat_prev <= {WIDTH{1'b0}};
    end else begin
      pat_q    <= pat_in;
      pat_prev <= pat_q;
    end
  end

  assign step      = (pat_q != pat_prev);
  assign oh        = is_onehot(pat_q);
  assign idx       = onehot_idx(pat_q);
  assign up        = (idx == pos + 3'd1);
  assign dn        = (idx == pos - 3'd1);
  assign dwell_clr = step | ((state == SEARCH) & oh);

  ripple_dwell_cnt #(
    .SHIFT_TIME(SHIFT_TIME),
    .TOL       (TOL),
    .CNT_W     (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (dwell_clr),
    .in_window(in_window),
    .timeout  (timeout)
  );

  // Next-state and error decision; one-hot beats step beats timing
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    dir_nxt   = dir;
    good_nxt  = good;
    eo_nxt    = 1'b0;
    es_nxt    = 1'b0;
    et_nxt    = 1'b0;
    case (state)
      SEARCH: begin
        if (oh) begin
          pos_nxt   = idx;
          state_nxt = ACQ;
        end else begin
          state_nxt = SEARCH;
        end
      end
      ACQ: begin
        if (!oh) begin
          eo_nxt = 1'b1;
        end else if (step) begin
          if (up || dn) begin
            dir_nxt   = up ? DIR_UP : ~DIR_UP;
            pos_nxt   = idx;
            good_nxt  = 2'd0;
            state_nxt = TRACK;
          end else begin
            es_nxt = 1'b1;
          end
        end else begin
          state_nxt = ACQ;
        end
      end
      TRACK, LOCK: begin
        if (!oh) begin
          eo_nxt = 1'b1;
        end else if (step) begin
          if ((dir == DIR_UP) ? !up : !dn) begin
            es_nxt = 1'b1;
          end else if (!in_window) begin
            et_nxt = 1'b1;
          end else begin
            pos_nxt = idx;
            if (state == TRACK) begin
              good_nxt = good + 2'd1;
              if (good == LAST_GOOD) begin
                state_nxt = LOCK;
              end else begin
                state_nxt = TRACK;
              end
            end else begin
              state_nxt = LOCK;
            end
          end
        end else if (timeout) begin
          et_nxt = 1'b1;
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        state_nxt = SEARCH;
      end
    endcase
    if (eo_nxt || es_nxt || et_nxt) begin
      state_nxt = SEARCH;
      dir_nxt   = 1'b0;
      good_nxt  = 2'd0;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      pos        <= 3'd0;
      dir        <= 1'b0;
      good       <= 2'd0;
      pos_valid  <= 1'b0;
      locked     <= 1'b0;
      err_onehot <= 1'b0;
      err_step   <= 1'b0;
      err_timing <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      dir        <= dir_nxt;
      good       <= good_nxt;
      pos_valid  <= (state_nxt != SEARCH);
      locked     <= (state_nxt == LOCK);
      err_onehot <= eo_nxt;
      err_step   <= es_nxt;
      err_timing <= et_nxt;
    end
  end

endmodule

// File: tb/tb_ripple_monitor.sv
// Randomized bench for ripple_monitor against a dwell/position reference model.
module tb_ripple_monitor;

  localparam int ST  = 10;
  localparam int TL  = 1;
  localparam int WLO = ST + 1 - TL;
  localparam int WHI = ST + 1 + TL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic [2:0] pos;
  logic       pos_valid, dir, locked, err_onehot, err_step, err_timing;

  ripple_monitor #(
    .WIDTH(8), .SHIFT_TIME(ST), .TOL(TL), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pat_in(pat_in), .pos(pos),
    .pos_valid(pos_valid), .dir(dir), .locked(locked),
    .err_onehot(err_onehot), .err_step(err_step), .err_timing(err_timing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_eo, n_es, n_et;

  // Reference model: mode 0 idle, 1 acquiring, 2 tracking, 3 locked
  int         m_mode, m_pos, m_good, ecount, ld_cur, ld_old;
  bit         m_dir;
  logic [7:0] mq, mprev;
  logic [8:0] exp_out;

  int cur, r, n;
  bit tdir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  function automatic int idx_of(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_good = 0; m_dir = 1'b0;
    mq = 8'h00; mprev = 8'h00; ld_cur = ecount; ld_old = ecount;
    exp_out = 9'd0;
  endtask

  task automatic model_edge();
    int d, ni;
    bit oh, stp, up, dn, eo, es, et;
    ecount++;
    stp = (mq != mprev);
    d   = stp ? (ld_cur - ld_old) : (ecount - 1 - ld_cur);
    oh  = ($countones(mq) == 1);
    ni  = idx_of(mq);
    up  = (ni == (m_pos + 1) % 8);
    dn  = (ni == (m_pos + 7) % 8);
    eo = 0; es = 0; et = 0;
    if (m_mode == 0) begin
      if (oh) begin m_pos = ni; m_mode = 1; end
    end else if (!oh) begin
      eo = 1;
    end else if (m_mode == 1) begin
      if (stp) begin
        if (up || dn) begin m_dir = up; m_pos = ni; m_mode = 2; m_good = 0; end
        else es = 1;
      end
    end else if (stp) begin
      if (!(m_dir ? up : dn)) es = 1;
      else if (d < WLO || d > WHI) et = 1;
      else begin
        m_pos = ni;
        if (m_mode == 2) begin
          m_good++;
          if (m_good == 3) m_mode = 3;
        end
      end
    end else if (d > WHI) begin
      et = 1;
    end
    if (eo || es || et) begin m_mode = 0; m_dir = 0; m_good = 0; end
    exp_out = {3'(m_pos), m_mode != 0, m_dir, m_mode == 3, eo, es, et};
    mprev = mq;
    if (pat_in != mq) begin ld_old = ld_cur; ld_cur = ecount; end
    mq = pat_in;
  endtask

  task automatic cyc(input logic [7:0] p);
    pat_in = p;
    @(posedge clk);
    model_edge();
    #2;
    check_eq("outs", {23'd0, pos, pos_valid, dir, locked, err_onehot, err_step, err_timing},
             {23'd0, exp_out});
    n_eo += int'(err_onehot);
    n_es += int'(err_step);
    n_et += int'(err_timing);
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] p, input int cycles);
    for (int k = 0; k < cycles; k++) cyc(p);
  endtask

  task automatic clr_cnt();
    n_eo = 0; n_es = 0; n_et = 0;
  endtask

  task automatic walk(input int steps, input bit up, input int dlo, input int dhi);
    for (int k = 0; k < steps; k++) begin
      cur = up ? (cur + 1) % 8 : (cur + 7) % 8;
      hold(pat(cur), $urandom_range(dhi, dlo));
    end
  endtask

  initial begin
    ecount = 0;
    model_reset();
    clr_cnt();
    #1;
    check_eq("reset_outs", {23'd0, pos, pos_valid, dir, locked, err_onehot, err_step, err_timing}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    hold(8'h00, 5);
    check_eq("search_zero_quiet", n_eo, 0);

    // Ascending with wrap, ending locked at position 3
    cur = 0;
    cyc(pat(0));
    check_eq("pv_lat1", pos_valid, 0);
    cyc(pat(0));
    check_eq("pv_lat2", pos_valid, 1);
    hold(pat(0), ST - 1);
    walk(11, 1'b1, WLO, WHI);
    check_eq("lock_up", locked, 1);
    check_eq("dir_up", dir, 1);
    check_eq("lock_pos3", pos, 3);
    check_eq("asc_no_err", n_eo + n_es + n_et, 0);

    // Jump 0x08 -> 0x20 while locked
    clr_cnt();
    cyc(8'h20);
    cyc(8'h20);
    check_eq("jump_es", err_step, 1);
    check_eq("jump_unlock", locked, 0);
    check_eq("jump_pv", pos_valid, 0);
    cyc(8'h20);
    check_eq("jump_reacq", pos_valid, 1);
    hold(8'h20, ST - 2);
    check_eq("jump_one_pulse", n_es, 1);

    // Descending with 0x01 -> 0x80 wrap
    clr_cnt();
    cur = 5;
    walk(10, 1'b0, WLO, WHI);
    check_eq("lock_down", locked, 1);
    check_eq("dir_down", dir, 0);
    check_eq("desc_no_err", n_eo + n_es + n_et, 0);

    // Dwell 10 and 12 pass, 9 fails
    clr_cnt();
    hold(pat(2), WLO);
    hold(pat(1), WHI);
    hold(pat(0), WLO - 1);
    hold(pat(7), 2);
    check_eq("short_dwell_et", n_et, 1);
    check_eq("short_dwell_only", n_eo + n_es, 0);
    cur = 7;
    hold(pat(7), ST - 1);
    walk(5, 1'b0, ST + 1, ST + 1);
    check_eq("relock", locked, 1);

    // Hold of 13 then step, and a long hold: one err_timing each
    clr_cnt();
    hold(pat(cur), 1);
    cur = (cur + 7) % 8;
    hold(pat(cur), WHI + 1);
    cur = (cur + 7) % 8;
    hold(pat(cur), 3);
    check_eq("dwell13_once", n_et, 1);
    walk(5, 1'b0, ST + 1, ST + 1);
    clr_cnt();
    hold(pat(cur), 30);
    check_eq("timeout_once", n_et, 1);

    // Non-one-hot while tracking
    walk(2, 1'b1, ST + 1, ST + 1);
    clr_cnt();
    hold(8'h00, 8);
    check_eq("zero_eo_once", n_eo, 1);
    cur = 0;
    hold(pat(0), ST + 1);
    walk(2, 1'b1, ST + 1, ST + 1);
    clr_cnt();
    hold(8'h03, 4);
    check_eq("multi_eo_once", n_eo, 1);

    // Async reset mid-LOCK
    cur = 4;
    hold(pat(4), ST + 1);
    walk(5, 1'b1, WLO, WHI);
    check_eq("pre_rst_lock", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", {23'd0, pos, pos_valid, dir, locked, err_onehot, err_step, err_timing}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr_cnt();
    cyc(pat(cur));
    cyc(pat(cur));
    check_eq("rst_reacq", pos_valid, 1);
    hold(pat(cur), ST - 1);
    walk(4, 1'b1, WLO, WHI);
    check_eq("rst_relock", locked, 1);
    check_eq("rst_no_err", n_eo + n_es + n_et, 0);

    // Random mix of legal, mistimed, illegal and corrupt patterns
    tdir = 1'b1;
    for (int s = 0; s < 90; s++) begin
      r = $urandom_range(9, 0);
      if (r <= 5) begin
        cur = tdir ? (cur + 1) % 8 : (cur + 7) % 8;
        n = (r == 0) ? $urandom_range(WHI + 1, WLO - 1) : $urandom_range(WHI, WLO);
        hold(pat(cur), n);
      end else if (r == 6) begin
        cur = (cur + $urandom_range(6, 2)) % 8;
        hold(pat(cur), $urandom_range(WHI, WLO));
      end else if (r == 7) begin
        hold(8'($urandom), $urandom_range(3, 1));
      end else if (r == 8) begin
        tdir = !tdir;
      end else begin
        hold(pat(cur), $urandom_range(20, 14));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
